hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit with an MDU scoreboard for a five-stage pipeline.
// Forwards MEM/WB results into EX, stalls on load-use and on reads of
// registers still owed by the multi-cycle multiply/divide unit, flushes on
// taken branches, and counts decode-stall cycles.
module hazard_scoreboard #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             mdu_opD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             mdu_startE,
  input  logic [REG_W-1:0] writeregM,
  input  logic             regwriteM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteW,
  input  logic             pcsrcM,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             mdu_busy,
  output logic             mdu_wb,
  output logic [REG_W-1:0] mdu_wreg,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NREG = 2 ** REG_W;
  // MDU_LAT is at most 15, so MDU_LAT-1 always fits in four bits.
  localparam int LAT_W = 4;

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_eff;
  logic [LAT_W-1:0] lat_cnt;
  logic             load_use;
  logic             sb_hazard;
  logic             start_ok;
  logic             start_bad;

  // MEM has priority over WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (src != '0 && src == writeregM && regwriteM)      return 2'b10;
    else if (src != '0 && src == writeregW && regwriteW) return 2'b01;
    else                                                 return 2'b00;
  endfunction

  // Forwarding selects for both EX operands.
  always_comb begin
    forwardAE = fwd_sel(rsE);
    forwardBE = fwd_sel(rtE);
  end

  // Hazard detection and stall/flush arbitration; a taken branch wins.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    stallF      = 1'b0;
    stallD      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    // The scoreboard reads as empty while reset is held.
    pending_eff = reset ? '0 : pending;
    load_use    = regwriteE && memtoregE && writeregE != '0 &&
                  (writeregE == rsD || writeregE == rtD);
    sb_hazard   = (rsD != '0 && pending_eff[rsD]) ||
                  (rtD != '0 && pending_eff[rtD]) ||
                  (mdu_opD && mdu_busy);
    if (pcsrcM) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use || sb_hazard) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign start_ok  = mdu_startE && !pcsrcM && !mdu_busy;
  // A flushed start is discarded entirely, so it cannot be a violation.
  assign start_bad = mdu_startE && !pcsrcM && mdu_busy;
  assign mdu_wb    = mdu_busy && lat_cnt == '0;

  // Scoreboard, MDU latency counter, sticky error flag and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      pending   <= '0;
      lat_cnt   <= '0;
      mdu_busy  <= 1'b0;
      mdu_wreg  <= '0;
      proto_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (mdu_busy) begin
        // The counter runs freely; pipeline stalls do not delay the MDU.
        if (lat_cnt == '0) begin
          mdu_busy           <= 1'b0;
          pending[mdu_wreg]  <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end else if (start_ok) begin
        mdu_busy <= 1'b1;
        lat_cnt  <= LAT_W'(MDU_LAT - 1);
        mdu_wreg <= writeregE;
        if (writeregE != '0) pending[writeregE] <= 1'b1;
      end
      if (start_bad) proto_err <= 1'b1;
      if (stallD && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters
// (REG_W=5, MDU_LAT=4, CNT_W=16). Inputs change 1 time unit after each
// rising edge; outputs are sampled a further 2 units later.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        mdu_opD, regwriteE, memtoregE, mdu_startE;
  logic        regwriteM, regwriteW, pcsrcM;
  logic [1:0]  forwardAE, forwardBE;
  logic        stallF, stallD, flushD, flushE;
  logic        mdu_busy, mdu_wb, proto_err;
  logic [4:0]  mdu_wreg;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .mdu_opD(mdu_opD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .mdu_startE(mdu_startE),
    .writeregM(writeregM), .regwriteM(regwriteM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .pcsrcM(pcsrcM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_wreg(mdu_wreg),
    .proto_err(proto_err), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; mdu_opD = 0; rsE = 0; rtE = 0; writeregE = 0;
    regwriteE = 0; memtoregE = 0; mdu_startE = 0;
    writeregM = 0; regwriteM = 0; writeregW = 0; regwriteW = 0; pcsrcM = 0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc(); cyc();
    // Reset state of registered outputs.
    settle();
    check("rst_busy", 32'(mdu_busy), 0);
    check("rst_wb", 32'(mdu_wb), 0);
    check("rst_wreg", 32'(mdu_wreg), 0);
    check("rst_perr", 32'(proto_err), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    // Hazard logic stays live during reset; counter must not move.
    regwriteE = 1; memtoregE = 1; writeregE = 9; rtD = 9;
    settle();
    check("rst_comb_stallD", 32'(stallD), 1);
    cyc();
    settle();
    check("rst_cnt_hold", 32'(stall_cnt), 0);

    reset = 1'b0;
    idle();
    cyc();
    // Forwarding: MEM beats WB, $0 never forwards, WB used when MEM idle.
    writeregM = 8; regwriteM = 1; writeregW = 8; regwriteW = 1; rsE = 8;
    settle();
    check("fwdA_mem", 32'(forwardAE), 32'b10);
    rsE = 0;
    settle();
    check("fwdA_zero", 32'(forwardAE), 32'b00);
    rtE = 8; regwriteM = 0;
    settle();
    check("fwdB_wb", 32'(forwardBE), 32'b01);

    // Load-use on rt for one cycle.
    idle();
    regwriteE = 1; memtoregE = 1; writeregE = 9; rtD = 9;
    settle();
    check("lu_stallF", 32'(stallF), 1);
    check("lu_stallD", 32'(stallD), 1);
    check("lu_flushE", 32'(flushE), 1);
    check("lu_flushD", 32'(flushD), 0);
    cyc();
    idle();
    settle();
    check("lu_cnt", 32'(stall_cnt), 1);
    check("lu_gone", 32'(stallD), 0);

    // MDU op to $16 issued in cycle 0, rsD=16 read throughout.
    cyc();
    mdu_startE = 1; writeregE = 16; rsD = 16;
    settle();
    check("mdu_c0_stall", 32'(stallD), 0);
    cyc();                                  // cycle 1
    mdu_startE = 0; writeregE = 0;
    settle();
    check("mdu_c1_busy", 32'(mdu_busy), 1);
    check("mdu_c1_wb", 32'(mdu_wb), 0);
    check("mdu_c1_stall", 32'(stallD), 1);
    cyc();                                  // cycle 2: MDU op in ID
    rsD = 0; mdu_opD = 1;
    settle();
    check("mdu_c2_opstall", 32'(stallD), 1);
    check("mdu_c2_wb", 32'(mdu_wb), 0);
    cyc();                                  // cycle 3
    rsD = 16; mdu_opD = 0;
    settle();
    check("mdu_c3_stall", 32'(stallD), 1);
    check("mdu_c3_wb", 32'(mdu_wb), 0);
    cyc();                                  // cycle 4
    settle();
    check("mdu_c4_wb", 32'(mdu_wb), 1);
    check("mdu_c4_wreg", 32'(mdu_wreg), 16);
    check("mdu_c4_stall", 32'(stallD), 1);
    cyc();                                  // cycle 5
    settle();
    check("mdu_c5_busy", 32'(mdu_busy), 0);
    check("mdu_c5_wb", 32'(mdu_wb), 0);
    check("mdu_c5_stall", 32'(stallD), 0);
    check("mdu_c5_cnt", 32'(stall_cnt), 5);

    // Start coinciding with a taken branch, load-use also present.
    idle();
    mdu_startE = 1; pcsrcM = 1; writeregE = 9; regwriteE = 1; memtoregE = 1; rtD = 9;
    settle();
    check("fl_flushD", 32'(flushD), 1);
    check("fl_flushE", 32'(flushE), 1);
    check("fl_stallD", 32'(stallD), 0);
    check("fl_stallF", 32'(stallF), 0);
    cyc();
    idle();
    settle();
    check("fl_busy", 32'(mdu_busy), 0);
    check("fl_cnt", 32'(stall_cnt), 5);
    check("fl_perr", 32'(proto_err), 0);

    // Op to $3 in cycle 0; WB write to $3 in cycle 1; second start (to $5) in cycle 2.
    mdu_startE = 1; writeregE = 3;
    cyc();                                  // cycle 1
    idle();
    writeregW = 3; regwriteW = 1;
    cyc();                                  // cycle 2
    idle();
    rsD = 3;
    mdu_startE = 1; writeregE = 5;
    settle();
    check("pe_wbw_keeps", 32'(stallD), 1);
    cyc();                                  // cycle 3
    idle();
    rtD = 5;
    settle();
    check("pe_set", 32'(proto_err), 1);
    check("pe_no_pend5", 32'(stallD), 0);
    cyc();                                  // cycle 4
    settle();
    check("pe_wb", 32'(mdu_wb), 1);
    check("pe_wreg", 32'(mdu_wreg), 3);
    cyc();                                  // cycle 5
    settle();
    check("pe_idle", 32'(mdu_busy), 0);
    check("pe_sticky", 32'(proto_err), 1);

    // Reset in cycle 2 of an op to $7.
    idle();
    mdu_startE = 1; writeregE = 7;
    cyc();                                  // cycle 1
    idle();
    cyc();                                  // cycle 2
    reset = 1'b1;
    cyc();                                  // cycle 3
    reset = 1'b0;
    rsD = 7;
    settle();
    check("rm_busy", 32'(mdu_busy), 0);
    check("rm_pend", 32'(stallD), 0);
    check("rm_perr", 32'(proto_err), 0);
    check("rm_cnt", 32'(stall_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      check("rm_no_wb", 32'(mdu_wb), 0);
      cyc();
    end

    // Hold a load-use stall for 2**16+3 edges: counter saturates.
    idle();
    regwriteE = 1; memtoregE = 1; writeregE = 9; rsD = 9;
    for (int i = 0; i < 65539; i++) cyc();
    settle();
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    check("sat_stall", 32'(stallD), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
